// File: rtl/cskip_sched_pkg.sv
// Shared types and constants for the carry-skip adder scheduler.
package cskip_sched_pkg;

  localparam int DATA_W  = 32;
  localparam int NUM_REQ = 2;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

endpackage

// File: rtl/carry_skip.sv
// Combinational carry-skip adder built from ripple blocks with a block-propagate bypass.
module carry_skip #(
  parameter int W   = 32,
  parameter int BLK = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o
);

  localparam int NBLK = W / BLK;

  logic [NBLK:0] blkCarry;
  logic          rippleC;
  logic          blkProp;

  // A block whose bits all propagate passes its incoming carry straight through.
  always_comb begin
    s_o         = '0;
    blkCarry    = '0;
    rippleC     = 1'b0;
    blkProp     = 1'b0;
    blkCarry[0] = cin_i;
    for (int k = 0; k < NBLK; k++) begin
      rippleC = blkCarry[k];
      blkProp = 1'b1;
      for (int i = 0; i < BLK; i++) begin
        s_o[k*BLK+i] = a_i[k*BLK+i] ^ b_i[k*BLK+i] ^ rippleC;
        rippleC      = (a_i[k*BLK+i] & b_i[k*BLK+i]) |
                       (rippleC & (a_i[k*BLK+i] ^ b_i[k*BLK+i]));
        blkProp      = blkProp & (a_i[k*BLK+i] ^ b_i[k*BLK+i]);
      end
      blkCarry[k+1] = blkProp ? blkCarry[k] : rippleC;
    end
    cout_o = blkCarry[NBLK];
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: on a tie, the requester that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/cskip_add_sched.sv
// Arbitrates two multi-word addition streams onto one carry-skip adder with a registered result stage.
// Optional job length guard: define CSKIP_SCHED_LEN_GUARD_EN.
module cskip_add_sched
  import cskip_sched_pkg::*;
#(
  parameter int WORDS_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        rq_valid,
  output logic [1:0]        rq_ready,
  input  logic [DATA_W-1:0] rq0_a,
  input  logic [DATA_W-1:0] rq0_b,
  input  logic [DATA_W-1:0] rq1_a,
  input  logic [DATA_W-1:0] rq1_b,
  input  logic [1:0]        rq_cin,
  input  logic [1:0]        rq_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_sum,
  output logic              res_cout,
  output logic              res_last,
  output logic              res_id,
  output logic              res_ovf
);

  if (WORDS_MAX < 2) begin : g_words_chk
    $error("WORDS_MAX must be at least 2");
  end

  state_e            state_q;
  logic              grant_q;
  logic              last_grant_q;
  logic              first_q;
  logic              carry_q;
  logic              res_valid_q;
  logic [DATA_W-1:0] res_sum_q;
  logic              res_cout_q;
  logic              res_last_q;
  logic              res_id_q;
  logic              res_ovf_q;

  logic [NUM_REQ-1:0] gnt;
  logic [DATA_W-1:0]  opA;
  logic [DATA_W-1:0]  opB;
  logic               addCin;
  logic [DATA_W-1:0]  sum_d;
  logic               cout_d;
  logic               accept;
  logic               forceLast;
  logic               beatLast;

  rr_arb2 u_arb (
    .req_i        (rq_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  // The stage may take a new beat whenever it is empty or draining this cycle.
  assign rq_ready = (state_q == S_BUSY && (!res_valid_q || res_ready)) ?
                    (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign accept   = (state_q == S_BUSY) && rq_valid[grant_q] && rq_ready[grant_q];
  assign opA      = grant_q ? rq1_a : rq0_a;
  assign opB      = grant_q ? rq1_b : rq0_b;
  assign addCin   = first_q ? rq_cin[grant_q] : carry_q;
  assign beatLast = rq_last[grant_q] | forceLast;

  carry_skip #(.W(DATA_W), .BLK(4)) u_add (
    .a_i    (opA),
    .b_i    (opB),
    .cin_i  (addCin),
    .s_o    (sum_d),
    .cout_o (cout_d)
  );

`ifdef CSKIP_SCHED_LEN_GUARD_EN
  localparam int CNT_W = $clog2(WORDS_MAX + 1);

  logic [CNT_W-1:0] cnt_q;

  assign forceLast = (cnt_q == CNT_W'(WORDS_MAX - 1)) && !rq_last[grant_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign forceLast = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      first_q      <= 1'b0;
      carry_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      res_sum_q    <= '0;
      res_cout_q   <= 1'b0;
      res_last_q   <= 1'b0;
      res_id_q     <= 1'b0;
      res_ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|rq_valid) begin
            grant_q <= gnt[1];
            first_q <= 1'b1;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (accept) begin
            carry_q <= cout_d;
            first_q <= 1'b0;
            if (beatLast) begin
              last_grant_q <= grant_q;
              state_q      <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (accept) begin
        res_valid_q <= 1'b1;
        res_sum_q   <= sum_d;
        res_cout_q  <= cout_d;
        res_last_q  <= beatLast;
        res_id_q    <= grant_q;
        res_ovf_q   <= forceLast;
      end else if (res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_last  = res_last_q;
  assign res_id    = res_id_q;
  assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_cskip_add_sched.sv
// Randomized self-checking bench for cskip_add_sched against a word-level multi-precision addition model.
module tb_cskip_add_sched;

  localparam int WORDS_MAX = 8;
`ifdef CSKIP_SCHED_LEN_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        last;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  rq_valid = '0;
  logic [1:0]  rq_ready;
  logic [31:0] rq0_a = '0, rq0_b = '0, rq1_a = '0, rq1_b = '0;
  logic [1:0]  rq_cin = '0;
  logic [1:0]  rq_last = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_sum;
  logic        res_cout, res_last, res_id, res_ovf;

  beat_t bq [2][$];
  exp_t  eq [2][$];
  int    latQ [2][$];
  int    jobIds [$];
  int    testsRun = 0;
  int    testsFailed = 0;
  bit    inJob = 0;
  logic  curOwner = 1'b0;
  bit    stallArm = 0;

  always #5 clk = ~clk;

  cskip_add_sched #(.WORDS_MAX(WORDS_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rq_valid  (rq_valid),
    .rq_ready  (rq_ready),
    .rq0_a     (rq0_a),
    .rq0_b     (rq0_b),
    .rq1_a     (rq1_a),
    .rq1_b     (rq1_b),
    .rq_cin    (rq_cin),
    .rq_last   (rq_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_last  (res_last),
    .res_id    (res_id),
    .res_ovf   (res_ovf)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pickWord();
    case ($urandom % 4)
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic pushBeat(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic last);
    beat_t bt;
    bt.a = a; bt.b = b; bt.cin = cin; bt.last = last;
    bq[r].push_back(bt);
  endtask

  task automatic pushExp(input int r, input logic [31:0] sum, input logic cout,
                         input logic last, input logic ovf);
    exp_t e;
    e.sum = sum; e.cout = cout; e.last = last; e.ovf = ovf;
    eq[r].push_back(e);
  endtask

  // Reference: a job is one long integer addition done a word at a time; a length-guard cut restarts from cin.
  task automatic pushJob(input int r, input int n, input logic cin);
    logic        c;
    logic [32:0] full;
    logic [31:0] a, b;
    logic        last, ovf;
    int          k;
    c = cin;
    k = 0;
    for (int i = 0; i < n; i++) begin
      a = pickWord();
      b = pickWord();
      last = (i == n - 1);
      pushBeat(r, a, b, cin, last);
      if (k == 0) c = cin;
      full = {1'b0, a} + {1'b0, b} + {32'd0, c};
      ovf  = GUARD && (k == WORDS_MAX - 1) && !last;
      pushExp(r, full[31:0], full[32], last || ovf, ovf);
      c = full[32];
      k = (last || ovf) ? 0 : k + 1;
    end
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_rq_ready"}, rq_ready, 0);
    checkOutput({pfx, "_res_valid"}, res_valid, 0);
    checkOutput({pfx, "_res_sum"}, res_sum, 0);
    checkOutput({pfx, "_res_cout"}, res_cout, 0);
    checkOutput({pfx, "_res_last"}, res_last, 0);
    checkOutput({pfx, "_res_id"}, res_id, 0);
    checkOutput({pfx, "_res_ovf"}, res_ovf, 0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    rq_valid = '0;
    res_ready = 1'b0;
    #1;
    checkResetOutputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    inJob = 0;
  endtask

  task automatic driveRequesters(input bit randValid);
    for (int r = 0; r < 2; r++) begin
      beat_t bt;
      bt.a = '0; bt.b = '0; bt.cin = 1'b0; bt.last = 1'b0;
      if (bq[r].size() > 0) bt = bq[r][0];
      rq_valid[r] = (bq[r].size() > 0) && (!randValid || ($urandom % 4 != 0));
      rq_cin[r]   = bt.cin;
      rq_last[r]  = bt.last;
      if (r == 0) begin rq0_a = bt.a; rq0_b = bt.b; end
      else        begin rq1_a = bt.a; rq1_b = bt.b; end
    end
  endtask

  // Cycle engine: drives both requesters from their beat queues and scores every drained result beat.
  task automatic applyStimulus(input bit randValid, input bit randReady, input bit latChk, input int budget);
    int   cyc;
    int   hold;
    int   idx;
    int   acc;
    exp_t e;
    cyc = 0;
    hold = 0;
    while ((bq[0].size() + bq[1].size() + eq[0].size() + eq[1].size()) > 0 && cyc < budget) begin
      driveRequesters(randValid);
      res_ready = (hold > 0) ? 1'b0 : (!randReady || ($urandom % 3 != 0));
      #1;
      checkOutput("one_ready", {63'd0, rq_ready == 2'b11}, 0);
      if (res_valid && !res_ready) checkOutput("bp_ready", rq_ready, 0);
      if (res_valid && res_ready) begin
        idx = res_id;
        if (eq[idx].size() == 0) begin
          checkOutput("unexpected_beat", 1, 0);
        end else begin
          e = eq[idx].pop_front();
          acc = latQ[idx].pop_front();
          checkOutput("sum", res_sum, e.sum);
          checkOutput("cout", res_cout, e.cout);
          checkOutput("last", res_last, e.last);
          checkOutput("ovf", res_ovf, e.ovf);
          if (latChk) checkOutput("latency", cyc - acc, 1);
          if (inJob) checkOutput("interleave", res_id, curOwner);
          else jobIds.push_back(idx);
          inJob = !res_last;
          curOwner = res_id;
          if (stallArm && !res_last) begin
            stallArm = 0;
            hold = 4;
          end
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (rq_valid[r] && rq_ready[r] && bq[r].size() > 0) begin
          void'(bq[r].pop_front());
          latQ[r].push_back(cyc);
        end
      end
      if (hold > 0) hold--;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= budget) begin
      checkOutput("timeout", 1, 0);
      for (int r = 0; r < 2; r++) begin
        bq[r].delete(); eq[r].delete(); latQ[r].delete();
      end
    end
    rq_valid = '0;
  endtask

  initial begin
    int waitCnt;

    doReset();

    // Single-word job with carry out.
    pushBeat(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    pushExp(0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    applyStimulus(0, 0, 1, 50);

    // Two-word job on rq1, carry chained into the upper word.
    pushBeat(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    pushBeat(1, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1);
    pushExp(1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    pushExp(1, 32'h0000_0002, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 0, 1, 50);

    // Both requesters valid from reset: jobs must alternate starting with rq0.
    doReset();
    jobIds.delete();
    for (int j = 0; j < 3; j++) begin
      pushJob(0, 2, 1'($urandom));
      pushJob(1, 2, 1'($urandom));
    end
    applyStimulus(0, 0, 1, 200);
    checkOutput("rr_count", jobIds.size(), 6);
    for (int j = 0; j < jobIds.size() && j < 6; j++)
      checkOutput($sformatf("rr_order%0d", j), jobIds[j], j % 2);

    // Downstream stall for three cycles mid-job.
    stallArm = 1;
    pushJob(1, 4, 1'b0);
    applyStimulus(0, 0, 0, 100);

    // Reset on the second beat of a three-beat job.
    doReset();
    rq0_a = 32'hFFFF_FFFF; rq0_b = 32'h1; rq_cin = 2'b00; rq_last = 2'b00;
    rq_valid = 2'b01; res_ready = 1'b1;
    waitCnt = 0;
    #1;
    while (!rq_ready[0] && waitCnt < 5) begin
      @(negedge clk);
      #1;
      waitCnt++;
    end
    checkOutput("rst_grant", rq_ready[0], 1);
    @(negedge clk);
    rq0_a = 32'h1; rq0_b = 32'h1;
    #1;
    checkOutput("rst_mid_ready", rq_ready, 2'b01);
    checkOutput("rst_mid_sum", res_sum, 0);
    checkOutput("rst_mid_cout", res_cout, 1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    rq_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    inJob = 0;
    pushBeat(0, 32'h0, 32'h0, 1'b0, 1'b1);
    pushExp(0, 32'h0, 1'b0, 1'b1, 1'b0);
    pushBeat(0, 32'h0, 32'h0, 1'b1, 1'b1);
    pushExp(0, 32'h1, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 0, 1, 50);

    // Ten-beat job: crosses the length guard when it is compiled in.
    pushJob(0, 10, 1'b1);
    applyStimulus(0, 0, 1, 100);

    // Random traffic with bubbles and backpressure.
    for (int j = 0; j < 12; j++) begin
      pushJob(0, 1 + $urandom % 10, 1'($urandom));
      pushJob(1, 1 + $urandom % 10, 1'($urandom));
    end
    applyStimulus(1, 1, 0, 5000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/cskip_add_sched.md
# cskip_add_sched

Sequencer and arbiter for the shared 32-bit carry-skip adder. Two requesters each submit multi-word addition jobs as streams of 32-bit operand beats. The block grants the adder to one requester for a whole job, chains the carry across beats, and returns registered sum beats on a single result stream tagged with the owner id. It sits between the multi-precision arithmetic clients and the `carry_skip` datapath instance.

## Interface
- `WORDS_MAX`, 8: maximum beats per job (used only with the length guard), ≥2.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rq_valid`  in  2  beat valid, bit r = requester r.
- `rq_ready`  out  2  beat accepted when `rq_valid[r] & rq_ready[r]`.
- `rq0_a`, `rq0_b`, `rq1_a`, `rq1_b`  in  32 each  operand words, least-significant word first.
- `rq_cin`  in  2  carry-in, sampled on the first beat of a job only.
- `rq_last`  in  2  marks the final beat of a job.
- `res_valid`  out  1  result beat valid.
- `res_ready`  in  1  downstream accept.
- `res_sum`  out  32  sum word.
- `res_cout`  out  1  carry out of this beat (meaningful as job carry on the last beat).
- `res_last`  out  1  final beat of a job.
- `res_id`  out  1  owning requester.
- `res_ovf`  out  1  job truncated by the length guard (constant 0 without the guard).

## Operation
- FSM states are IDLE and BUSY. Reset state is IDLE, with `grant_q=0` and `last_grant_q=1` so requester 0 wins first.
- IDLE arbitration:
  - No `rq_valid` bit set: stay in IDLE.
  - One bit set: grant that requester.
  - Both set: grant `~last_grant_q` (round-robin).
  - Next state is BUSY. Set `first_q=1`.
- BUSY:
  - `rq_ready[grant_q] = ~res_valid | res_ready`. The other `rq_ready` bit is 0.
  - On an accepted beat, the adder input carry is `first_q ? rq_cin[grant_q] : carry_q`.
  - Register `{sum, cout, last, id}` into the result stage. Set `carry_q=cout` and `first_q=0`.
  - On an accepted beat with `rq_last`: set `last_grant_q=grant_q` and go to IDLE.
- The result stage is a single-entry skid-free register.
  - Set `res_valid` on accept; clear it on `res_valid & res_ready` with no new accept.
  - Simultaneous drain and accept: reload the stage and keep `res_valid=1`.
- A non-granted requester holds its beat; it is never dropped.
- In IDLE, `rq_ready=0`.
- Reset mid-job: all state clears and the job is abandoned. Requesters restart from the first word.

## Timing
- Reset values: `rq_ready=0`, `res_valid=0`, `res_sum=0`, `res_cout=0`, `res_last=0`, `res_id=0`, `res_ovf=0`.
- Grant latency: first beat accepted no earlier than 1 cycle after `rq_valid` rises in IDLE.
- Beat-to-result latency: 1 cycle.
- Throughput: 1 beat/cycle with `res_ready=1`.
- Job turnaround: last beat at cycle t, IDLE at t+1, next job's first beat at t+2 at the earliest.
- Backpressure: `res_ready=0` with `res_valid=1` forces `rq_ready=0` in the same cycle.

## Configuration
- `CSKIP_SCHED_LEN_GUARD_EN` defined:
  - A beat counter of width clog2(WORDS_MAX+1) runs per job.
  - When the WORDS_MAX-th beat is accepted without `rq_last`, the block treats it as last: `res_last=1`, `res_ovf=1`, and the FSM returns to IDLE.
  - The requester's remaining beats form a new job that competes normally.
- Undefined: no counter. Jobs are unbounded and `res_ovf` is tied to 0.

## Structure
- Shared package `cskip_sched_pkg`:
  - State enum `{S_IDLE, S_BUSY}`.
  - `DATA_W=32`.
  - `NUM_REQ=2`.
- Sub-module `rr_arb2`: two-input round-robin arbiter with `last_grant` input and one-hot grant output.
- The `carry_skip` adder is instantiated once. Only `s[31:0]` and `cout` are used.

## Test plan
- Single-word job, rq0: a=0xFFFFFFFF, b=0x00000001, cin=0 → res_sum=0x00000000, res_cout=1, res_last=1, res_id=0, one cycle after accept.
- Two-word job, rq1: {0x00000001,0xFFFFFFFF}+{0x00000000,0x00000001}, LSW first → beats 0x00000000/cout=1, then 0x00000002/cout=0; carry chained.
- Both requesters valid from reset, each sending 2-beat jobs → order rq0, rq1, rq0, and rq0 beats are never interleaved with rq1 beats.
- `res_ready=0` for 3 cycles mid-job → `rq_ready` low, result held stable, no beat lost or duplicated; sums correct after release.
- Reset asserted on the 2nd beat of a 3-beat job → all outputs at reset values immediately; a fresh job afterwards uses rq_cin, not the stale carry.
- Guard enabled, WORDS_MAX=8, 10-beat job without `rq_last` until beat 10 → beat 8 has res_last=1 and res_ovf=1; beats 9–10 are a new job with cin from `rq_cin`.
